timer_display_clock: RTL and testbench
======================================

Name: timer_display_clock

Overview:
Elapsed-time stage that sits directly downstream of the 1 s interval timer in the timer_display system. It counts rising edges of the timer's interrupt line as seconds and keeps an mm:ss value in BCD, 00:00 to 59:59. Four 7-segment digits are decoded for the board HEX displays. Firmware controls and observes the block through a small Avalon-MM slave with registered reads. The firmware ISR clears the timer status, which produces one tick_in rising edge per second.

Parameters:
WRAP_DEFAULT, 1, reset value of CONTROL.wrap_en.
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (DE-board HEX); 0 = active-high.

Ports:
clk  in  1  system clock (same clock as the timer)
reset  in  1  synchronous, active-high reset
tick_in  in  1  timer irq level; each rising edge is one second
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
overflow_irq  out  1  CONTROL.irq_en AND STATUS.overflow
hex0  out  7  seconds ones, segments {g,f,e,d,c,b,a}
hex1  out  7  seconds tens
hex2  out  7  minutes ones
hex3  out  7  minutes tens

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge; it aborts any operation in progress. After reset:
  - all digits = 0, run = 0, wrap_en = WRAP_DEFAULT, irq_en = 0, overflow = 0;
  - readdata = 0; overflow_irq = 0;
  - hex0..hex3 = code for "0" (7'b1000000 when SEG_ACTIVE_LOW);
  - tick_d = 1, so a tick_in already high at reset release does not count.
- Edge detect: tick_d <= tick_in every cycle. tick_ev = tick_in & ~tick_d & run.
- Counter update occurs on the same edge that first samples tick_in high. A 1-cycle tick_in pulse counts once; a level held high counts once.
- BCD cascade on tick_ev:
  - s_ones 0..9 carries into s_tens 0..5;
  - s_tens carries into m_ones 0..9;
  - m_ones carries into m_tens 0..5.
- 59:59 + tick:
  - wrap_en = 1: go to 00:00 and set overflow.
  - wrap_en = 0: hold 59:59, set overflow, clear run.
- Register map. Writes take effect when chipselect & ~write_n. Reads: readdata <= mux(address) every cycle, 1-cycle latency.
  - 0 CONTROL, write:
    - bit0 run;
    - bit1 clear (strobe, not stored): zeroes all digits;
    - bit2 wrap_en;
    - bit3 irq_en.
  - 0 CONTROL, read: {12'b0, irq_en, wrap_en, 1'b0, run}.
  - 1 TIME, read: {m_tens, m_ones, s_tens, s_ones}, 4 bits each.
  - 1 TIME, write: load all four digits. If any nibble is out of range (m_tens>5, m_ones>9, s_tens>5, s_ones>9), the whole write is ignored and no digit changes.
  - 2 STATUS, read: {15'b0, overflow}. Any write clears overflow.
  - 3 reserved: reads 0, writes ignored.
- Priority within one cycle (highest first): reset > CONTROL.clear > valid TIME write > tick_ev.
  - A tick that loses to clear or a TIME write is dropped, not deferred.
  - Overflow set beats a STATUS clear in the same cycle.
  - A CONTROL write and a tick_ev in the same cycle: the tick uses the old run value; the new CONTROL bits apply from the next cycle.
- Display: hex_n registered from the current digit registers, so the display lags the digit change by 1 cycle.
  - Decode 0-9 as standard 7-seg.
  - Out-of-range nibble (unreachable) shows all segments off.
  - SEG_ACTIVE_LOW inverts the pattern.
- overflow_irq: combinational AND of registered bits; glitch-free.

Test Plan:
1. Reset, then CONTROL=0x1, then 3 tick_in pulses -> TIME reads 0x0003; hex0 = 7'b0110000 one cycle after the third tick.
2. TIME write 0x0959, then one tick -> TIME = 0x1000 (full carry chain); hex3..hex0 show 1,0,0,0.
3. wrap_en=1, irq_en=1, TIME=0x5959, one tick -> TIME=0x0000, STATUS=1, overflow_irq=1. STATUS write -> overflow_irq=0 next cycle.
4. wrap_en=0, TIME=0x5959, one tick -> TIME stays 0x5959, CONTROL.run reads 0, overflow=1; further ticks change nothing.
5. TIME write 0x0A00 -> ignored, TIME unchanged. CONTROL=0x3 (clear) coincident with a tick_in edge -> TIME=0x0000, tick dropped.
6. tick_in held high across reset deassertion, then run=1 -> no count until tick_in falls and rises again. Reset asserted mid-count at TIME=0x0130 -> all registers back to reset values on the next edge.

Source files
------------

// File: rtl/timer_display_clock.sv
// rtl/timer_display_clock.sv - mm:ss BCD elapsed-time counter with 7-segment decode and register slave
// Counts rising edges of tick_in as seconds while running; firmware access through a 4-word register map.
module timer_display_clock #(
   parameter bit WRAP_DEFAULT   = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        overflow_irq,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3
);

   logic [3:0]  r_s_ones, r_s_tens, r_m_ones, r_m_tens;
   logic        r_run, r_wrap_en, r_irq_en, r_overflow, r_tick_d;

   logic        w_wr, w_ctrl_wr, w_clear, w_time_ld, w_stat_wr;
   logic        w_tick_ev, w_at_max, w_time_ok;
   logic [15:0] w_rd_mux;

   // Pattern is built active-high {g,f,e,d,c,b,a}; unreachable codes blank the digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return SEG_ACTIVE_LOW ? ~p : p;
   endfunction

   assign w_wr      = chipselect & ~write_n;
   assign w_ctrl_wr = w_wr && (address == 2'd0);
   assign w_clear   = w_ctrl_wr & writedata[1];
   assign w_stat_wr = w_wr && (address == 2'd2);
   assign w_time_ok = (writedata[15:12] <= 4'd5) && (writedata[11:8] <= 4'd9) &&
                      (writedata[7:4]   <= 4'd5) && (writedata[3:0]  <= 4'd9);
   assign w_time_ld = w_wr && (address == 2'd1) && w_time_ok;

   assign w_tick_ev = tick_in & ~r_tick_d & r_run;
   assign w_at_max  = (r_m_tens == 4'd5) && (r_m_ones == 4'd9) &&
                      (r_s_tens == 4'd5) && (r_s_ones == 4'd9);

   assign overflow_irq = r_irq_en & r_overflow;

   always_comb begin
      w_rd_mux = 16'h0000;
      case (address)
         2'd0:    w_rd_mux = {12'b0, r_irq_en, r_wrap_en, 1'b0, r_run};
         2'd1:    w_rd_mux = {r_m_tens, r_m_ones, r_s_tens, r_s_ones};
         2'd2:    w_rd_mux = {15'b0, r_overflow};
         default: w_rd_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_ones   <= 4'd0;
         r_s_tens   <= 4'd0;
         r_m_ones   <= 4'd0;
         r_m_tens   <= 4'd0;
         r_run      <= 1'b0;
         r_wrap_en  <= WRAP_DEFAULT;
         r_irq_en   <= 1'b0;
         r_overflow <= 1'b0;
         // A tick_in already high at release must not look like a fresh edge.
         r_tick_d   <= 1'b1;
         readdata   <= 16'h0000;
         hex0       <= seg7(4'd0);
         hex1       <= seg7(4'd0);
         hex2       <= seg7(4'd0);
         hex3       <= seg7(4'd0);
      end else begin
         r_tick_d <= tick_in;
         readdata <= w_rd_mux;
         hex0     <= seg7(r_s_ones);
         hex1     <= seg7(r_s_tens);
         hex2     <= seg7(r_m_ones);
         hex3     <= seg7(r_m_tens);

         if (w_ctrl_wr) begin
            r_run     <= writedata[0];
            r_wrap_en <= writedata[2];
            r_irq_en  <= writedata[3];
         end
         if (w_stat_wr)
            r_overflow <= 1'b0;

         // Clear and TIME loads swallow a coincident tick; overflow set is last so it beats a STATUS clear.
         if (w_clear) begin
            r_s_ones <= 4'd0;
            r_s_tens <= 4'd0;
            r_m_ones <= 4'd0;
            r_m_tens <= 4'd0;
         end else if (w_time_ld) begin
            r_m_tens <= writedata[15:12];
            r_m_ones <= writedata[11:8];
            r_s_tens <= writedata[7:4];
            r_s_ones <= writedata[3:0];
         end else if (w_tick_ev) begin
            if (w_at_max) begin
               r_overflow <= 1'b1;
               if (r_wrap_en) begin
                  r_s_ones <= 4'd0;
                  r_s_tens <= 4'd0;
                  r_m_ones <= 4'd0;
                  r_m_tens <= 4'd0;
               end else begin
                  r_run <= 1'b0;
               end
            end else if (r_s_ones != 4'd9) begin
               r_s_ones <= r_s_ones + 4'd1;
            end else begin
               r_s_ones <= 4'd0;
               if (r_s_tens != 4'd5) begin
                  r_s_tens <= r_s_tens + 4'd1;
               end else begin
                  r_s_tens <= 4'd0;
                  if (r_m_ones != 4'd9) begin
                     r_m_ones <= r_m_ones + 4'd1;
                  end else begin
                     r_m_ones <= 4'd0;
                     r_m_tens <= r_m_tens + 4'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_display_clock.sv
// tb/tb_timer_display_clock.sv - scoreboard bench for timer_display_clock
// Reference keeps elapsed time as whole seconds and converts to BCD/segments only when predicting outputs.
module tb_timer_display_clock;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick_in = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'h0000;
   logic [15:0] readdata;
   logic        overflow_irq;
   logic [6:0]  hex0, hex1, hex2, hex3;

   always #5 clk = ~clk;

   timer_display_clock #(.WRAP_DEFAULT(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .tick_in(tick_in), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .overflow_irq(overflow_irq),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
   );

   typedef struct {
      int          tag;
      int          kind;
      logic [31:0] exp;
   } item_t;

   item_t exp_q[$];
   int    cur_tag = 0;
   int    mon_tag = 0;
   int    drv_tag = 0;
   int    vectors = 0;
   int    miscompares = 0;
   string phase = "init";

   int m_secs;
   bit m_run, m_wrap, m_irq, m_ovf, m_tick_d;

   function automatic logic [6:0] m_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [15:0] m_time();
      int mm = m_secs / 60;
      int ss = m_secs % 60;
      logic [3:0] a, b, c, d;
      a = 4'(mm / 10); b = 4'(mm % 10); c = 4'(ss / 10); d = 4'(ss % 10);
      return {a, b, c, d};
   endfunction

   function automatic logic [31:0] m_hex();
      int mm = m_secs / 60;
      int ss = m_secs % 60;
      return {4'b0, m_seg(mm / 10), m_seg(mm % 10), m_seg(ss / 10), m_seg(ss % 10)};
   endfunction

   function automatic logic [15:0] m_read(input logic [1:0] a);
      case (a)
         2'd0: return {12'b0, m_irq, m_wrap, 1'b0, m_run};
         2'd1: return m_time();
         2'd2: return {15'b0, m_ovf};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_step(input bit cs, input bit wn, input logic [1:0] a,
                             input logic [15:0] wd, input bit tk);
      bit wr = cs && !wn;
      bit ev = tk && !m_tick_d && m_run;
      bit ok = (wd[15:12] <= 4'd5) && (wd[11:8] <= 4'd9) && (wd[7:4] <= 4'd5) && (wd[3:0] <= 4'd9);
      bit old_wrap = m_wrap;
      m_tick_d = tk;
      if (wr && a == 2'd0) begin
         m_run = wd[0]; m_wrap = wd[2]; m_irq = wd[3];
      end
      if (wr && a == 2'd2) m_ovf = 1'b0;
      if (wr && a == 2'd0 && wd[1]) begin
         m_secs = 0;
      end else if (wr && a == 2'd1 && ok) begin
         m_secs = (int'(wd[15:12]) * 10 + int'(wd[11:8])) * 60 + int'(wd[7:4]) * 10 + int'(wd[3:0]);
      end else if (ev) begin
         if (m_secs == 3599) begin
            m_ovf = 1'b1;
            if (old_wrap) m_secs = 0;
            else m_run = 1'b0;
         end else begin
            m_secs = m_secs + 1;
         end
      end
   endtask

   // Every cycle: readdata and display reflect pre-edge state, overflow_irq reflects post-edge state.
   task automatic do_cycle(input bit cs, input bit wn, input logic [1:0] a,
                           input logic [15:0] wd, input bit tk);
      @(negedge clk);
      reset = 1'b0; chipselect = cs; write_n = wn; address = a; writedata = wd; tick_in = tk;
      drv_tag++;
      exp_q.push_back('{drv_tag, 0, {16'b0, m_read(a)}});
      exp_q.push_back('{drv_tag, 1, m_hex()});
      model_step(cs, wn, a, wd, tk);
      exp_q.push_back('{drv_tag, 2, {31'b0, m_irq & m_ovf}});
      cur_tag = drv_tag;
      @(posedge clk);
   endtask

   task automatic do_reset(input bit tk);
      @(negedge clk);
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 16'h0; tick_in = tk;
      drv_tag++;
      m_secs = 0; m_run = 1'b0; m_wrap = 1'b1; m_irq = 1'b0; m_ovf = 1'b0; m_tick_d = 1'b1;
      exp_q.push_back('{drv_tag, 0, 32'h0});
      exp_q.push_back('{drv_tag, 1, m_hex()});
      exp_q.push_back('{drv_tag, 2, 32'h0});
      cur_tag = drv_tag;
      @(posedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d, input bit tk);
      do_cycle(1'b1, 1'b0, a, d, tk);
   endtask

   task automatic rd(input logic [1:0] a, input bit tk);
      do_cycle(1'b1, 1'b1, a, 16'h0, tk);
   endtask

   task automatic idle(input bit tk);
      do_cycle(1'b0, 1'b1, 2'd0, 16'h0, tk);
   endtask

   task automatic pulse();
      idle(1'b1);
      idle(1'b0);
   endtask

   always @(posedge clk) mon_tag <= cur_tag;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].tag == mon_tag) begin : pop_one
         item_t       it;
         logic [31:0] act;
         string       kname;
         it = exp_q.pop_front();
         case (it.kind)
            0:       begin act = {16'b0, readdata}; kname = "readdata"; end
            1:       begin act = {4'b0, hex3, hex2, hex1, hex0}; kname = "hex3..hex0"; end
            default: begin act = {31'b0, overflow_irq}; kname = "overflow_irq"; end
         endcase
         vectors++;
         if (act !== it.exp) begin
            miscompares++;
            $display("FAIL %s %s cycle=%0d got=%h want=%h", phase, kname, it.tag, act, it.exp);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          tk;
      logic [15:0] wd;
      logic [3:0]  n0, n1, n2, n3;

      phase = "reset_count";
      do_reset(1'b0);
      wr(2'd0, 16'h0001, 1'b0);
      repeat (3) pulse();
      rd(2'd1, 1'b0);

      phase = "carry_chain";
      wr(2'd1, 16'h0959, 1'b0);
      pulse();
      rd(2'd1, 1'b0);
      idle(1'b0);

      phase = "wrap_irq";
      wr(2'd0, 16'h000D, 1'b0);
      wr(2'd1, 16'h5959, 1'b0);
      pulse();
      rd(2'd1, 1'b0);
      rd(2'd2, 1'b0);
      wr(2'd2, 16'h0000, 1'b0);
      idle(1'b0);

      phase = "ovf_beats_clear";
      wr(2'd1, 16'h5959, 1'b0);
      wr(2'd2, 16'h0000, 1'b1);
      rd(2'd2, 1'b0);
      wr(2'd2, 16'h0000, 1'b0);

      phase = "hold_at_max";
      wr(2'd0, 16'h0001, 1'b0);
      wr(2'd1, 16'h5959, 1'b0);
      pulse();
      rd(2'd0, 1'b0);
      rd(2'd2, 1'b0);
      repeat (2) pulse();
      rd(2'd1, 1'b0);

      phase = "bad_time_clear";
      wr(2'd1, 16'h0A00, 1'b0);
      rd(2'd1, 1'b0);
      wr(2'd0, 16'h0001, 1'b0);
      wr(2'd0, 16'h0003, 1'b1);
      idle(1'b0);
      rd(2'd1, 1'b0);

      phase = "load_beats_tick";
      wr(2'd1, 16'h0120, 1'b1);
      idle(1'b0);
      rd(2'd1, 1'b0);

      phase = "ctrl_old_run";
      wr(2'd0, 16'h0000, 1'b0);
      wr(2'd0, 16'h0001, 1'b1);
      idle(1'b0);
      wr(2'd0, 16'h0000, 1'b1);
      idle(1'b0);
      rd(2'd1, 1'b0);

      phase = "tick_high_reset";
      do_reset(1'b1);
      wr(2'd0, 16'h0001, 1'b1);
      repeat (3) idle(1'b1);
      idle(1'b0);
      idle(1'b1);
      rd(2'd1, 1'b1);

      phase = "reset_mid_count";
      wr(2'd1, 16'h0130, 1'b0);
      wr(2'd0, 16'h000D, 1'b0);
      pulse();
      do_reset(1'b0);
      rd(2'd0, 1'b0);
      rd(2'd1, 1'b0);
      rd(2'd2, 1'b0);

      phase = "random";
      tk = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 2) == 0) tk = ~tk;
         if (r < 8) begin
            wd = 16'($urandom);
            wd[0] = ($urandom_range(0, 3) != 0);
            wd[1] = ($urandom_range(0, 15) == 0);
            // Run-clear on hold and a same-cycle CONTROL write would collide; keep the edge away.
            if (m_secs == 3599 && m_run) tk = m_tick_d;
            wr(2'd0, wd, tk);
         end else if (r < 18) begin
            case ($urandom_range(0, 3))
               0: begin
                  n3 = 4'($urandom_range(0, 5)); n2 = 4'($urandom_range(0, 9));
                  n1 = 4'($urandom_range(0, 5)); n0 = 4'($urandom_range(0, 9));
                  wd = {n3, n2, n1, n0};
               end
               1: wd = 16'h5959;
               2: wd = 16'h5958;
               default: wd = 16'($urandom);
            endcase
            wr(2'd1, wd, tk);
         end else if (r < 22) begin
            wr(2'd2, 16'($urandom), tk);
         end else if (r < 24) begin
            wr(2'd3, 16'($urandom), tk);
         end else if (r < 60) begin
            rd(2'($urandom_range(0, 3)), tk);
         end else if (r == 99 && $urandom_range(0, 3) == 0) begin
            do_reset(tk);
         end else begin
            idle(tk);
         end
      end

      phase = "drain";
      idle(1'b0);
      idle(1'b0);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
